pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch front end of the single-cycle-memory MIPS core. It generates the fetch address for the combinational FetchInstruction memory and captures the returned word into an IF/ID pipeline register for the decode stage. It handles stall, branch/jump redirect, flush, halt and a one-cycle boot bubble after reset.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_next_mux.sv | 34 +++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   // sll $0,$0,0
   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: jump over taken branch over stall over sequential.
module pc_next_mux
   import mips_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic              stall,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] next_pc,
   output logic              take_redirect,
   output logic              misalign
);

   // Redirect targets are forced word-aligned; misalign flags dropped low bits.
   always_comb begin
      next_pc       = pc + 32'd4;
      take_redirect = 1'b0;
      misalign      = 1'b0;
      if (jump) begin
         next_pc       = {jump_target[ADDR_W-1:2], 2'b00};
         take_redirect = 1'b1;
         misalign      = (jump_target[1:0] != 2'b00);
      end else if (branch_taken) begin
         next_pc       = {branch_target[ADDR_W-1:2], 2'b00};
         take_redirect = 1'b1;
         misalign      = (branch_target[1:0] != 2'b00);
      end else if (stall) begin
         next_pc = pc;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, IF/ID pipeline register, fetch counter and fetch FSM.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
   parameter int unsigned        CNT_W    = 16,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic               halt,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc4,
   output logic               ifid_valid,
   output logic               misalign_err,
   output logic [CNT_W-1:0]   fetch_count,
   output logic [1:0]         state_o
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] next_pc;
   logic              take_redirect;
   logic              misalign;

   pc_next_mux u_pc_next_mux (
      .pc            (pc),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc),
      .take_redirect (take_redirect),
      .misalign      (misalign)
   );

   assign imem_addr = pc;
   assign state_o   = state;

   // Fetch FSM: halt beats redirect beats stall beats sequential capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         ifid_instr   <= NOP_WORD;
         ifid_pc4     <= '0;
         ifid_valid   <= 1'b0;
         misalign_err <= 1'b0;
         fetch_count  <= '0;
      end else begin
         case (state)
            BOOT: begin
               state      <= RUN;
               ifid_valid <= 1'b0;
            end
            RUN: begin
               if (halt) begin
                  state      <= HALT;
                  ifid_instr <= NOP_WORD;
                  ifid_valid <= 1'b0;
               end else if (take_redirect) begin
                  pc         <= next_pc;
                  ifid_instr <= NOP_WORD;
                  ifid_valid <= 1'b0;
                  if (misalign) misalign_err <= 1'b1;
               end else if (!stall) begin
                  // next_pc is pc+4 on this path, which is also the captured PC+4
                  pc          <= next_pc;
                  ifid_instr  <= imem_data;
                  ifid_pc4    <= next_pc;
                  ifid_valid  <= 1'b1;
                  fetch_count <= fetch_count + 1'b1;
               end
            end
            HALT: begin
               ifid_valid <= 1'b0;
            end
            default: begin
               state      <= BOOT;
               ifid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: reference model feeds a scoreboard queue,
// a vector table drives the main sequence, hand sequences cover reset.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        halt;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        misalign_err;
   logic [15:0] fetch_count;
   logic [1:0]  state_o;

   int n_checks = 0;
   int n_fail   = 0;

   pc_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (16),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .halt          (halt),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .misalign_err  (misalign_err),
      .fetch_count   (fetch_count),
      .state_o       (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'd4) return 32'h2008_0005;
      return a ^ 32'hDEAD_0000;
   endfunction

   always_comb imem_data = mem(imem_addr);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        err;
      logic [15:0] cnt;
      logic [1:0]  st;
   } exp_t;

   exp_t q[$];

   // Reference model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_err;
   logic [15:0] m_cnt;
   logic [1:0]  m_st;

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_err = 1'b0; m_cnt = 16'h0; m_st = 2'd0;
   endtask

   task automatic model_step(input logic st, input logic jp, input logic br,
                             input logic hl, input logic [31:0] jt,
                             input logic [31:0] bt);
      case (m_st)
         2'd0: begin m_st = 2'd1; m_valid = 1'b0; end
         2'd1: begin
            if (hl) begin
               m_st = 2'd2; m_instr = 32'h0; m_valid = 1'b0;
            end else if (jp) begin
               m_pc = {jt[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
               if (jt[1:0] != 2'b00) m_err = 1'b1;
            end else if (br) begin
               m_pc = {bt[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
               if (bt[1:0] != 2'b00) m_err = 1'b1;
            end else if (!st) begin
               m_instr = mem(m_pc);
               m_pc4   = m_pc + 32'd4;
               m_pc    = m_pc + 32'd4;
               m_valid = 1'b1;
               m_cnt   = m_cnt + 16'd1;
            end
         end
         default: m_valid = 1'b0;
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check_all(input exp_t e);
      check("imem_addr",    imem_addr,              e.addr);
      check("ifid_instr",   ifid_instr,             e.instr);
      check("ifid_pc4",     ifid_pc4,               e.pc4);
      check("ifid_valid",   {31'd0, ifid_valid},    {31'd0, e.valid});
      check("misalign_err", {31'd0, misalign_err},  {31'd0, e.err});
      check("fetch_count",  {16'd0, fetch_count},   {16'd0, e.cnt});
      check("state_o",      {30'd0, state_o},       {30'd0, e.st});
   endtask

   // Drive one cycle of inputs, predict, clock, then compare
   task automatic step(input logic st, input logic jp, input logic br,
                       input logic hl, input logic [31:0] jt,
                       input logic [31:0] bt);
      exp_t e;
      stall = st; jump = jp; branch_taken = br; halt = hl;
      jump_target = jt; branch_target = bt;
      model_step(st, jp, br, hl, jt, bt);
      e = '{m_pc, m_instr, m_pc4, m_valid, m_err, m_cnt, m_st};
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard: queue empty");
      end else begin
         e = q.pop_front();
         check_all(e);
      end
   endtask

   typedef struct {
      logic        st, jp, br, hl;
      logic [31:0] jt, bt;
      logic [31:0] exp_addr;
      logic        exp_valid;
   } vec_t;

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_0000, 0}; // BOOT
      vecs[1]  = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_0004, 1};
      vecs[2]  = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_0008, 1};
      vecs[3]  = '{1,0,0,0, 32'h0,        32'h0,   32'h0000_0008, 1};
      vecs[4]  = '{1,0,0,0, 32'h0,        32'h0,   32'h0000_0008, 1};
      vecs[5]  = '{1,0,0,0, 32'h0,        32'h0,   32'h0000_0008, 1};
      vecs[6]  = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_000C, 1};
      vecs[7]  = '{1,1,1,0, 32'h40,       32'h80,  32'h0000_0040, 0};
      vecs[8]  = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_0044, 1};
      vecs[9]  = '{0,0,1,0, 32'h0,        32'h102, 32'h0000_0100, 0};
      vecs[10] = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_0104, 1};
      vecs[11] = '{0,1,0,0, 32'hFFFF_FFFC, 32'h0,  32'hFFFF_FFFC, 0};
      vecs[12] = '{0,0,0,0, 32'h0,        32'h0,   32'h0000_0000, 1};
      vecs[13] = '{0,0,0,1, 32'h0,        32'h0,   32'h0000_0000, 0};
      vecs[14] = '{1,1,0,0, 32'h40,       32'h0,   32'h0000_0000, 0};

      rst_n = 1'b0;
      stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
      jump_target = '0; branch_target = '0;
      model_reset();

      #2;
      check("rst_addr",  imem_addr,  32'h0);
      check("rst_instr", ifid_instr, 32'h0);
      check("rst_valid", {31'd0, ifid_valid}, 32'd0);
      check("rst_state", {30'd0, state_o},    32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].st, vecs[i].jp, vecs[i].br, vecs[i].hl,
              vecs[i].jt, vecs[i].bt);
         check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_valid", i), {31'd0, ifid_valid},
               {31'd0, vecs[i].exp_valid});
         if (i == 2) begin
            check("instr_at_4", ifid_instr, 32'h2008_0005);
            check("pc4_at_4",   ifid_pc4,   32'h0000_0008);
         end
         if (i == 7) begin
            check("flush_nop", ifid_instr, 32'h0);
            check("aligned_no_err", {31'd0, misalign_err}, 32'd0);
         end
      end
      check("halt_state",  {30'd0, state_o},      32'd2);
      check("sticky_err",  {31'd0, misalign_err}, 32'd1);
      check("halt_count",  {16'd0, fetch_count},  32'd6);

      // Mid-cycle asynchronous reset pulse
      rst_n = 1'b0;
      #1;
      check("async_state", {30'd0, state_o},      32'd0);
      check("async_err",   {31'd0, misalign_err}, 32'd0);
      check("async_addr",  imem_addr,             32'h0);
      check("async_count", {16'd0, fetch_count},  32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Boot, one fetch, then wrap from the top of the address space
      step(0, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h0);
      step(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h0);
      check("wrap_addr", imem_addr,             32'h0);
      check("wrap_pc4",  ifid_pc4,              32'h0);
      check("wrap_err",  {31'd0, misalign_err}, 32'd0);

      // Misaligned jump after a stall; jump target wins over branch
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 1, 1, 0, 32'h203, 32'h300);
      check("mis_jump_addr", imem_addr,             32'h200);
      check("mis_jump_err",  {31'd0, misalign_err}, 32'd1);
      step(0, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog: timeout expired");
      $fatal(1, "timeout");
   end

endmodule
